// File: rtl/camera_frame_reader_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Package    : camera_pkg
//  Purpose    : Shared types and constants for the camera frame reader:
//               controller state encoding, default frame geometry, RGB565
//               field positions and the pixel FIFO entry layout.
//  Revision   : 1.0  initial release
// ============================================================================
package camera_pkg;

    // Default frame geometry: 320x240 pixels, one pixel per RAM word.
    localparam int unsigned C_FRAME_PIXELS = 76800;
    localparam int unsigned C_ADDR_W       = 17;
    localparam int unsigned C_PIX_W        = 16;

    // RGB565 field positions inside a pixel word.
    localparam int unsigned C_RGB_R_MSB = 15;
    localparam int unsigned C_RGB_R_LSB = 11;
    localparam int unsigned C_RGB_G_MSB = 10;
    localparam int unsigned C_RGB_G_LSB = 5;
    localparam int unsigned C_RGB_B_MSB = 4;
    localparam int unsigned C_RGB_B_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_REL   = 3'd4
    } state_t;

    // One output FIFO entry: frame-last marker plus the RGB565 pixel.
    typedef struct packed {
        logic               last;
        logic [C_PIX_W-1:0] data;
    } pix_entry_t;

endpackage
`default_nettype wire

// File: rtl/camera_frame_reader_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Interface  : camera_frame_reader_if
//  Purpose    : Valid/ready RGB565 pixel stream with frame-last marker.
//  Signals    : pix_valid  source -> sink   pixel present
//               pix_ready  sink   -> source pixel accepted this cycle
//               pix_data   source -> sink   RGB565 pixel
//               pix_last   source -> sink   final pixel of the frame
//  Modports   : master = stream source (frame reader), slave = stream sink
//  Revision   : 1.0  initial release
// ============================================================================
interface camera_frame_reader_if;
    logic        pix_valid;
    logic        pix_ready;
    logic [15:0] pix_data;
    logic        pix_last;

    modport master (output pix_valid, output pix_data, output pix_last, input pix_ready);
    modport slave  (input pix_valid, input pix_data, input pix_last, output pix_ready);
endinterface
`default_nettype wire

// File: rtl/camera_pix_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module     : camera_pix_fifo
//  Purpose    : 2-entry first-word-fall-through FIFO of {last, pixel}.
//               The head entry is visible on o_rdata while o_count != 0.
//  Ports      : clk, rst_n     clock, asynchronous active-low reset
//               i_flush        synchronous clear, wins over push/pop
//               i_push/i_wdata write one entry (caller guarantees room)
//               i_pop          consume head entry (ignored when empty)
//               o_rdata        head entry
//               o_count        occupancy 0..2
//  Revision   : 1.0  initial release
// ============================================================================
module camera_pix_fifo
    import camera_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       rst_n,
    input  wire logic       i_flush,
    input  wire logic       i_push,
    input  wire pix_entry_t i_wdata,
    input  wire logic       i_pop,
    output pix_entry_t      o_rdata,
    output logic [1:0]      o_count
);

    pix_entry_t r_mem [2];
    logic       r_wptr;
    logic       r_rptr;
    logic [1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign w_do_pop  = i_pop && (r_count != 2'd0);
    assign w_do_push = i_push && ((r_count != 2'd2) || w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_count  <= 2'd0;
        end else if (i_flush) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wptr] <= i_wdata;
                r_wptr        <= ~r_wptr;
            end
            if (w_do_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rptr];
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/camera_frame_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module     : camera_frame_reader
//  Purpose    : HCLK-side frame fetch. Requests a frame from the PCLK capture
//               stage (DATA_VALID), waits for its synchronized DATA_READY,
//               streams every stored pixel from the dual-port RAM read port
//               as a valid/ready stream, then releases the capture stage.
//  Ports      : HCLK, HRESETn   clock, asynchronous active-low reset
//               start, abort    frame request pulse / transfer abort level
//               busy, done      not-idle flag / completion pulse
//               DATA_VALID      capture request to the PCLK stage
//               DATA_READY      frame-captured flag (asynchronous)
//               DualRAM_RADDR   RAM read address
//               DualRAM_RDATA   RAM read data, 1-cycle latency, [15:0] used
//               pix             pixel stream source (master modport)
//  Revision   : 1.0  initial release
// ============================================================================
module camera_frame_reader
    import camera_pkg::*;
#(
    parameter int unsigned FRAME_PIXELS = C_FRAME_PIXELS,
    parameter int unsigned ADDR_W       = C_ADDR_W
) (
    input  wire logic              HCLK,
    input  wire logic              HRESETn,
    input  wire logic              start,
    input  wire logic              abort,
    output logic                   busy,
    output logic                   done,
    output logic                   DATA_VALID,
    input  wire logic              DATA_READY,
    output logic [ADDR_W-1:0]      DualRAM_RADDR,
    input  wire logic [31:0]       DualRAM_RDATA,
    camera_frame_reader_if.master  pix
);

    // One extra counter bit so a frame of exactly 2^ADDR_W pixels never wraps.
    localparam logic [ADDR_W:0] c_last_addr = (ADDR_W+1)'(FRAME_PIXELS - 1);
    localparam logic [ADDR_W:0] c_one       = (ADDR_W+1)'(1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_rdy_meta;
    logic              r_rdy_s;
    logic              r_done;
    logic [ADDR_W:0]   r_cnt;
    logic              r_inflight;
    logic              r_inflight_last;

    logic              w_issue;
    logic              w_flush;
    logic              w_data_valid;
    logic              w_pop;
    logic              w_room;
    logic [2:0]        w_occ;
    logic [1:0]        w_fifo_count;
    pix_entry_t        w_fifo_head;
    pix_entry_t        w_fifo_wdata;
    logic              w_unused_rdata_hi;

    assign w_unused_rdata_hi = &{1'b0, DualRAM_RDATA[31:16]};

    assign pix.pix_valid = (w_fifo_count != 2'd0);
    assign pix.pix_data  = pix.pix_valid ? w_fifo_head.data : 16'h0000;
    assign pix.pix_last  = pix.pix_valid & w_fifo_head.last;
    assign w_pop         = pix.pix_valid & pix.pix_ready;

    // Entries already buffered plus the read in flight, minus what leaves
    // this cycle, must stay below 2 for a new read to be safe.
    assign w_occ  = {1'b0, w_fifo_count} + {2'b00, r_inflight};
    assign w_room = w_occ < (3'd2 + {2'b00, w_pop});

    always_comb begin
        w_state_nxt  = r_state;
        w_issue      = 1'b0;
        w_data_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // A start coinciding with the done pulse is dropped.
                if (start && !r_done) w_state_nxt = ST_REQ;
            end
            ST_REQ: begin
                w_data_valid = 1'b1;
                if (abort)        w_state_nxt = ST_REL;
                else if (r_rdy_s) w_state_nxt = ST_READ;
            end
            ST_READ: begin
                w_data_valid = 1'b1;
                if (abort) begin
                    w_state_nxt = ST_REL;
                end else if (w_room) begin
                    w_issue = 1'b1;
                    if (r_cnt == c_last_addr) w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                w_data_valid = 1'b1;
                if (abort || (w_pop && pix.pix_last)) w_state_nxt = ST_REL;
            end
            ST_REL: begin
                if (!r_rdy_s) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Entering REL (normal completion or abort) discards all datapath state.
    assign w_flush = (w_state_nxt == ST_REL) && (r_state != ST_REL);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state         <= ST_IDLE;
            r_rdy_meta      <= 1'b0;
            r_rdy_s         <= 1'b0;
            r_done          <= 1'b0;
            r_cnt           <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_rdy_meta      <= DATA_READY;
            r_rdy_s         <= r_rdy_meta;
            r_done          <= (r_state == ST_REL) && !r_rdy_s;
            r_inflight      <= w_issue && !w_flush;
            r_inflight_last <= w_issue && !w_flush && (r_cnt == c_last_addr);
            if (w_flush)      r_cnt <= '0;
            else if (w_issue) r_cnt <= r_cnt + c_one;
        end
    end

    assign w_fifo_wdata = {r_inflight_last, DualRAM_RDATA[15:0]};

    camera_pix_fifo u_fifo (
        .clk     (HCLK),
        .rst_n   (HRESETn),
        .i_flush (w_flush),
        .i_push  (r_inflight),
        .i_wdata (w_fifo_wdata),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_head),
        .o_count (w_fifo_count)
    );

    assign busy          = (r_state != ST_IDLE);
    assign done          = r_done;
    assign DATA_VALID    = w_data_valid;
    assign DualRAM_RADDR = r_cnt[ADDR_W-1:0];

endmodule
`default_nettype wire

// File: tb/tb_camera_frame_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module     : tb_camera_frame_reader
//  Purpose    : Self-checking bench. Instance 0 reads a 16-pixel frame with a
//               4-bit address (frame fills the whole address space); instance
//               1 reads a 1-pixel frame. Expected pixels come from a queue
//               built from the frame contents (word k = 0x1000+k).
//  Revision   : 1.0  initial release
// ============================================================================
module tb_camera_frame_reader;

    localparam int N0  = 16;
    localparam int AW0 = 4;
    localparam int N1  = 1;
    localparam int AW1 = 1;

    logic HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    logic HRESETn;

    // Instance 0
    logic           start0, abort0, DATA_READY0;
    logic           busy0, done0, dv0;
    logic [AW0-1:0] raddr0;
    logic [31:0]    rdata0;
    camera_frame_reader_if u_if0 ();

    camera_frame_reader #(.FRAME_PIXELS(N0), .ADDR_W(AW0)) u_dut0 (
        .HCLK          (HCLK),
        .HRESETn       (HRESETn),
        .start         (start0),
        .abort         (abort0),
        .busy          (busy0),
        .done          (done0),
        .DATA_VALID    (dv0),
        .DATA_READY    (DATA_READY0),
        .DualRAM_RADDR (raddr0),
        .DualRAM_RDATA (rdata0),
        .pix           (u_if0)
    );

    // Synchronous-read RAM: low half is the pixel, high half is noise.
    always @(posedge HCLK) rdata0 <= {16'($urandom), 16'h1000 + 16'(raddr0)};

    // Instance 1
    logic           start1, abort1, DATA_READY1;
    logic           busy1, done1, dv1;
    logic [AW1-1:0] raddr1;
    logic [31:0]    rdata1;
    camera_frame_reader_if u_if1 ();

    camera_frame_reader #(.FRAME_PIXELS(N1), .ADDR_W(AW1)) u_dut1 (
        .HCLK          (HCLK),
        .HRESETn       (HRESETn),
        .start         (start1),
        .abort         (abort1),
        .busy          (busy1),
        .done          (done1),
        .DATA_VALID    (dv1),
        .DATA_READY    (DATA_READY1),
        .DualRAM_RADDR (raddr1),
        .DualRAM_RDATA (rdata1),
        .pix           (u_if1)
    );

    always @(posedge HCLK) rdata1 <= {16'hFFFF, 16'hA000 + 16'(raddr1)};

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          accepted;
    int          first_acc;
    int          last_acc;
    logic [16:0] exp_q [$];
    bit          prev_stall;
    logic [16:0] prev_pix;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic load_frame(input int n);
        exp_q.delete();
        for (int k = 0; k < n; k++) exp_q.push_back({(k == n - 1), 16'h1000 + 16'(k)});
        accepted   = 0;
        first_acc  = -1;
        last_acc   = -1;
        prev_stall = 1'b0;
    endtask

    // Observes the current cycle of instance 0 (inputs already driven),
    // then advances to the next negative edge.
    task automatic clk_step();
        logic [16:0] obs;
        logic [16:0] exp;
        #1;
        obs = {u_if0.pix_last, u_if0.pix_data};
        if (prev_stall) begin
            chk("stall_valid", 32'(u_if0.pix_valid), 32'd1);
            chk("stall_hold", 32'(obs), 32'(prev_pix));
        end
        if (busy0) chk("reads_ahead", 32'(int'(raddr0) <= accepted + 2), 32'd1);
        if (u_if0.pix_valid && u_if0.pix_ready) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL extra_pixel observed=0x%0h expected=none", obs);
            end
            if (exp_q.size() != 0) begin
                exp = exp_q.pop_front();
                chk("pixel", 32'(obs), 32'(exp));
            end
            if (accepted == 0) first_acc = cyc;
            last_acc = cyc;
            accepted++;
        end
        prev_stall = u_if0.pix_valid && !u_if0.pix_ready;
        prev_pix   = obs;
        @(negedge HCLK);
        cyc++;
    endtask

    task automatic full_frame(input bit rand_ready, input bit spam);
        int t_r;
        load_frame(N0);
        u_if0.pix_ready = 1'b1;
        start0 = 1'b1;
        clk_step();
        start0 = 1'b0;
        chk("req_busy", 32'(busy0), 32'd1);
        chk("req_dv", 32'(dv0), 32'd1);
        chk("req_addr", 32'(raddr0), 32'd0);
        for (int i = 0; i < 5; i++) begin
            start0 = spam;
            clk_step();
        end
        start0      = 1'b0;
        DATA_READY0 = 1'b1;
        t_r         = cyc;
        for (int i = 0; i < 400 && accepted < N0; i++) begin
            u_if0.pix_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            start0 = spam && (i % 3 == 0);
            clk_step();
        end
        start0 = 1'b0;
        u_if0.pix_ready = 1'b1;
        chk("frame_count", 32'(accepted), 32'(N0));
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        if (!rand_ready) begin
            chk("first_latency", 32'(first_acc - t_r), 32'd5);
            chk("last_latency", 32'(last_acc - t_r), 32'(N0 + 4));
        end
        chk("rel_dv", 32'(dv0), 32'd0);
        chk("rel_busy", 32'(busy0), 32'd1);
        chk("rel_valid", 32'(u_if0.pix_valid), 32'd0);
        clk_step();
        clk_step();
        chk("rel_hold_done", 32'(done0), 32'd0);
        chk("rel_hold_busy", 32'(busy0), 32'd1);
        DATA_READY0 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("done_timing", 32'(done0), 32'(k == 3));
            chk("busy_timing", 32'(busy0), 32'(k < 3));
            start0 = spam && (k == 3);
            clk_step();
        end
        start0 = 1'b0;
        if (spam) begin
            for (int k = 0; k < 4; k++) begin
                chk("start_ignored_busy", 32'(busy0), 32'd0);
                chk("start_ignored_dv", 32'(dv0), 32'd0);
                clk_step();
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        int n1;
        HRESETn = 1'b0;
        start0 = 1'b0; abort0 = 1'b0; DATA_READY0 = 1'b0; u_if0.pix_ready = 1'b0;
        start1 = 1'b0; abort1 = 1'b0; DATA_READY1 = 1'b0; u_if1.pix_ready = 1'b0;
        load_frame(N0);
        @(negedge HCLK);
        clk_step();
        clk_step();
        // Reset values
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_done", 32'(done0), 32'd0);
        chk("rst_dv", 32'(dv0), 32'd0);
        chk("rst_valid", 32'(u_if0.pix_valid), 32'd0);
        chk("rst_last", 32'(u_if0.pix_last), 32'd0);
        chk("rst_data", 32'(u_if0.pix_data), 32'd0);
        chk("rst_addr", 32'(raddr0), 32'd0);
        chk("rst_busy1", 32'(busy1), 32'd0);
        chk("rst_dv1", 32'(dv1), 32'd0);
        HRESETn = 1'b1;
        clk_step();
        clk_step();

        // Full frame, ready held high
        full_frame(1'b0, 1'b0);
        clk_step();

        // Random backpressure
        full_frame(1'b1, 1'b0);
        clk_step();

        // Abort mid-READ after 5 accepted pixels
        load_frame(N0);
        u_if0.pix_ready = 1'b1;
        start0 = 1'b1;
        clk_step();
        start0 = 1'b0;
        clk_step();
        DATA_READY0 = 1'b1;
        for (int i = 0; i < 100 && accepted < 5; i++) clk_step();
        chk("abort_pre", 32'(accepted), 32'd5);
        abort0 = 1'b1;
        u_if0.pix_ready = 1'b0;
        clk_step();
        abort0 = 1'b0;
        prev_stall = 1'b0;
        chk("abort_dv", 32'(dv0), 32'd0);
        chk("abort_valid", 32'(u_if0.pix_valid), 32'd0);
        chk("abort_busy", 32'(busy0), 32'd1);
        chk("abort_addr", 32'(raddr0), 32'd0);
        u_if0.pix_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("abort_no_valid", 32'(u_if0.pix_valid), 32'd0);
            clk_step();
        end
        DATA_READY0 = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (done0) got = 1'b1;
            clk_step();
        end
        chk("abort_done", 32'(got), 32'd1);
        chk("abort_idle", 32'(busy0), 32'd0);
        exp_q.delete();
        full_frame(1'b0, 1'b0);
        clk_step();

        // start spammed while busy and in the done cycle
        full_frame(1'b0, 1'b1);
        clk_step();

        // Reset in DRAIN with two pixels buffered
        load_frame(N0);
        u_if0.pix_ready = 1'b1;
        start0 = 1'b1;
        clk_step();
        start0 = 1'b0;
        clk_step();
        DATA_READY0 = 1'b1;
        for (int i = 0; i < 100 && accepted < 14; i++) clk_step();
        chk("drain_pre", 32'(accepted), 32'd14);
        u_if0.pix_ready = 1'b0;
        for (int i = 0; i < 3; i++) clk_step();
        chk("drain_valid", 32'(u_if0.pix_valid), 32'd1);
        chk("drain_data", 32'(u_if0.pix_data), 32'h100E);
        chk("drain_busy", 32'(busy0), 32'd1);
        HRESETn = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy0), 32'd0);
        chk("mid_rst_done", 32'(done0), 32'd0);
        chk("mid_rst_dv", 32'(dv0), 32'd0);
        chk("mid_rst_valid", 32'(u_if0.pix_valid), 32'd0);
        chk("mid_rst_last", 32'(u_if0.pix_last), 32'd0);
        chk("mid_rst_data", 32'(u_if0.pix_data), 32'd0);
        chk("mid_rst_addr", 32'(raddr0), 32'd0);
        prev_stall = 1'b0;
        DATA_READY0 = 1'b0;
        clk_step();
        clk_step();
        HRESETn = 1'b1;
        u_if0.pix_ready = 1'b1;
        clk_step();
        chk("post_rst_valid", 32'(u_if0.pix_valid), 32'd0);
        chk("post_rst_busy", 32'(busy0), 32'd0);
        exp_q.delete();
        full_frame(1'b0, 1'b0);
        clk_step();

        // Single-pixel frame on instance 1
        u_if1.pix_ready = 1'b1;
        start1 = 1'b1;
        clk_step();
        start1 = 1'b0;
        chk("one_dv", 32'(dv1), 32'd1);
        chk("one_addr", 32'(raddr1), 32'd0);
        DATA_READY1 = 1'b1;
        n1 = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (u_if1.pix_valid && u_if1.pix_ready) begin
                n1++;
                chk("one_data", 32'(u_if1.pix_data), 32'hA000);
                chk("one_last", 32'(u_if1.pix_last), 32'd1);
            end
            clk_step();
        end
        chk("one_count", 32'(n1), 32'd1);
        chk("one_rel_dv", 32'(dv1), 32'd0);
        chk("one_rel_busy", 32'(busy1), 32'd1);
        DATA_READY1 = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (done1) got = 1'b1;
            clk_step();
        end
        chk("one_done", 32'(got), 32'd1);
        chk("one_idle", 32'(busy1), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
